// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning the HI/LO registers.
// The result is computed at issue, then held in a shadow until the count ends.
module muldiv_hilo_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   shadow_q, shadow_d;
  logic          upd_q, upd_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic        sgn;
  logic [63:0] ea, eb, prod;
  logic        neg_a, neg_b;
  logic [31:0] ua, ub, ub_nz, uq, ur, q, r;

  assign sgn  = ~op[0];
  assign ea   = {{32{sgn & rs_val[31]}}, rs_val};
  assign eb   = {{32{sgn & rt_val[31]}}, rt_val};
  assign prod = ea * eb;

  // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN with no overflow case.
  assign neg_a = sgn & rs_val[31];
  assign neg_b = sgn & rt_val[31];
  assign ua    = neg_a ? -rs_val : rs_val;
  assign ub    = neg_b ? -rt_val : rt_val;
  assign ub_nz = (ub == 32'd0) ? 32'd1 : ub;
  assign uq    = ua / ub_nz;
  assign ur    = ua % ub_nz;
  assign q     = (neg_a ^ neg_b) ? -uq : uq;
  assign r     = neg_a ? -ur : ur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      upd_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      upd_q    <= upd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    upd_d    = upd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            3'd0, 3'd1: begin
              shadow_d = prod;
              upd_d    = 1'b1;
              cnt_d    = CW'(MUL_CYCLES - 1);
              state_d  = MUL;
            end
            3'd2, 3'd3: begin
              shadow_d = {r, q};
              upd_d    = (rt_val != 32'd0);
              cnt_d    = CW'(DIV_CYCLES - 1);
              state_d  = DIV;
            end
            3'd4: hi_d = rs_val;
            3'd5: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (cnt_q == '0) begin
          if (upd_q) {hi_d, lo_d} = shadow_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  a_no_start_busy: assert property (
    @(posedge clk) disable iff (reset) !(start && busy)
  );

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl.
// Hand-computed HI/LO results and busy-window length.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ohi, input logic [31:0] olo,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input string tag);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0; op = 3'd6;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (i == n - 1) begin
        chk({tag, "_hi_hold"}, hi, ohi);
        chk({tag, "_lo_hold"}, lo, olo);
      end
      tick();
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; rs_val = a; rt_val = 32'd0;
    chk("mt_busy_pre", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0; op = 3'd6;
    chk("mt_busy_post", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd6;
    rs_val = '0; rt_val = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA,
           32'hFFFF_FFFE, 32'h0000_0001, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFE, 32'h0000_0001,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'h0000_0000, 32'h8000_0000, "div_min");
    run_op(3'd3, 32'd100, 32'd7, 10,
           32'h0000_0000, 32'h8000_0000,
           32'd2, 32'd14, "divu");

    run_mt(3'd4, 32'h11);
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_lo", lo, 32'd14);
    run_mt(3'd5, 32'h22);
    chk("mtlo_lo", lo, 32'h22);

    run_op(3'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22,
           32'h11, 32'h22, "divu0");

    run_mt(3'd4, 32'hDEAD_BEEF);
    chk("mthi2_hi", hi, 32'hDEAD_BEEF);
    chk("mthi2_lo", lo, 32'h22);

    run_mt(3'd6, 32'h1234_5678);
    chk("noop_hi", hi, 32'hDEAD_BEEF);
    chk("noop_lo", lo, 32'h22);

    start = 1'b1; op = 3'd2; rs_val = 32'd50; rt_val = 32'd5;
    tick();
    start = 1'b0; op = 3'd6;
    tick(); tick(); tick();
    chk("abort_busy4", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    tick(); tick();
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_lo2", lo, 32'd0);
    run_mt(3'd5, 32'd5);
    chk("post_lo", lo, 32'd5);
    chk("post_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
